posit_enc_8_1_pipe: RTL and testbench
=====================================

Name: posit_enc_8_1_pipe

Overview:
- Two-stage pipelined posit encoder. Takes decoded fields (sign, signed regime k, exponent, fraction, zero/NaR flags) in the same format the decoder emits and packs them into an n-bit posit word.
- Applies round-to-nearest-even and posit saturation rules.
- Sits on the write-back side of the posit datapath, after arithmetic units.
- Valid/ready handshake on both ends, with full back-pressure.

Parameters:
- n, 8, posit word width
- es, 1, exponent field width
- rs, 4, width of signed regime value k (two's complement)
- fs, n-es-3, fraction field width (hidden bit excluded)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input fields valid
- in_ready  output  1  encoder can accept input this cycle
- in_sign  input  1  sign of value
- in_k  input  rs  signed regime value k
- in_e  input  es  exponent field
- in_frac  input  fs  fraction field, MSB-aligned
- in_zero  input  1  value is zero
- in_inf  input  1  value is NaR
- out_valid  output  1  out_posit valid
- out_ready  input  1  downstream accepts
- out_posit  output  n  encoded posit

Behaviour:
- Reset/handshake:
  - Reset is asynchronous, active-low.
  - Reset values: s1_valid=0, out_valid=0, out_posit=0, all stage data registers 0.
  - Reset asserted mid-operation discards in-flight items. No output appears after reset release until new input is accepted.
  - Transfer occurs when valid & ready are both high at a clk edge.
  - Stage-2 output register loads when !out_valid | out_ready.
  - Stage 1 loads when !s1_valid | stage-2 loads.
  - in_ready = !s1_valid | stage-2 load condition (combinational from out_ready).
  - Latency: 2 cycles from input accept to out_valid. Sustained throughput is 1 word/cycle with out_ready high.
  - While out_valid=1 & out_ready=0, out_posit holds stable. Two items may be in flight; a third is refused (in_ready=0).
- Stage 1 (build):
  - Regime string, k>=0: (k+1) ones then a single 0. Regime string, k<0: (-k) zeros then a single 1.
  - Concatenate regime, in_e, in_frac into a 2n-bit MSB-first buffer.
  - Take the top n-1 bits as magnitude m. The next bit is guard g; the OR of all remaining bits is sticky s.
  - Register m, g, s, plus flags: sign, zero, nar, sat_hi (k >= n-2), sat_lo (k < -(n-2)).
- Stage 2 (round/pack):
  - Round up if g & (s | m[0]).
  - If m = all-ones and rounding up, hold at all-ones (maxpos, never NaR).
  - Result is never rounded to 0: if m = 0, force 1 (minpos).
  - sat_hi gives magnitude 2^(n-1)-1 (maxpos). sat_lo gives magnitude 1 (minpos).
  - out_posit = sign ? two's-complement of {0,m'} : {0,m'}.
  - Priority: in_inf (out = 1 followed by zeros) > in_zero (out = 0) > saturation > rounding. in_sign is ignored for zero and NaR.
- Round-trip: any decoder output with zero=inf=0, fed back, re-encodes to the original word bit-exact.

Decomposition:
- Shared package posit_pkg holds:
  - Defaults for N/ES/RS/FS.
  - NaR and zero constants.
  - maxpos/minpos magnitude functions.
  - Regime-length function.
- One natural sub-module: posit_round_pack (stage-2 combinational round/saturate/negate), reusable by other posit producers.
- Stage 1 and the handshake stay in the top module.

Test Plan:
- k=0, e=0, frac=0000, sign=0 -> 0x40. Same with sign=1 -> 0xC0. k=-1, e=0, frac=0 -> 0x20. Each appears exactly 2 cycles after accept.
- k=5, e=1, frac=0000 (tie, lsb 0) -> 0x7E. k=5, e=1, frac=1000 (sticky) -> 0x7F. k=6 -> 0x7F. k=7 -> 0x7F (saturate).
- k=-6 -> 0x01. k=-7 or k=-8 -> 0x01 (never zero). in_inf=1 with in_zero=1 -> 0x80. in_zero=1, sign=1 -> 0x00.
- Streaming: 16 back-to-back inputs with out_ready=1 -> 16 outputs on consecutive cycles, in order, in_ready constant 1.
- Back-pressure: two inputs accepted, then out_ready=0 for 3 cycles -> in_ready=0 after second accept, out_posit stable, no loss or duplication when out_ready returns.
- Reset asserted with 2 items in flight -> out_valid=0 and out_posit=0 immediately (asynchronous). No stale output after release. Plus a round-trip sweep of all 256 posits through the decoder model -> identical words except 0x00/0x80 flag cases.

Source files
------------

// File: rtl/posit_pkg.sv
// Shared posit<8,1> definitions: field widths, special encodings, magnitude
// helpers and the stage record passed from the build stage to round/pack.
package posit_pkg;

  localparam int N  = 8;
  localparam int ES = 1;
  localparam int RS = 4;
  localparam int FS = N - ES - 3;

  localparam logic [N-1:0] POSIT_ZERO = '0;
  localparam logic [N-1:0] POSIT_NAR  = {1'b1, {(N-1){1'b0}}};

  function automatic logic [N-2:0] maxpos_mag();
    return {(N-1){1'b1}};
  endfunction

  function automatic logic [N-2:0] minpos_mag();
    return {{(N-2){1'b0}}, 1'b1};
  endfunction

  // Regime run plus its terminating bit: k+2 for k>=0, 1-k for k<0.
  function automatic int unsigned regime_len(logic signed [RS-1:0] k);
    int ki;
    ki = int'(k);
    return (ki >= 0) ? int'(ki + 2) : int'(1 - ki);
  endfunction

  typedef struct packed {
    logic [N-2:0] m;
    logic         g;
    logic         s;
    logic         sign;
    logic         zero;
    logic         nar;
    logic         sat_hi;
    logic         sat_lo;
  } enc_stage_t;

endpackage

// File: rtl/posit_round_pack.sv
// Round-to-nearest-even, saturation and sign application for a built posit
// magnitude; purely combinational so any posit producer can reuse it.
module posit_round_pack
  import posit_pkg::*;
(
  input  enc_stage_t   st,
  output logic [N-1:0] posit
);

  logic         round_up;
  logic [N-2:0] m_r;
  logic [N-1:0] mag;

  always_comb begin
    round_up = st.g & (st.s | st.m[0]);
    // An all-ones magnitude must not carry into the sign bit (that would be NaR).
    if (&st.m) m_r = st.m;
    else       m_r = st.m + {{(N-2){1'b0}}, round_up};
    if (m_r == '0) m_r = minpos_mag();
    if (st.sat_hi)      m_r = maxpos_mag();
    else if (st.sat_lo) m_r = minpos_mag();

    mag = {1'b0, m_r};
    if (st.nar)       posit = POSIT_NAR;
    else if (st.zero) posit = POSIT_ZERO;
    else if (st.sign) posit = -mag;
    else              posit = mag;
  end

endmodule

// File: rtl/posit_enc_8_1_pipe.sv
// Two-stage posit<8,1> encoder: stage 1 builds the regime/exponent/fraction
// bit string and extracts guard/sticky, stage 2 rounds and packs.
module posit_enc_8_1_pipe
  import posit_pkg::*;
#(
  parameter int n  = N,
  parameter int es = ES,
  parameter int rs = RS,
  parameter int fs = n - es - 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [rs-1:0] in_k,
  input  logic [es-1:0] in_e,
  input  logic [fs-1:0] in_frac,
  input  logic          in_zero,
  input  logic          in_inf,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [n-1:0]  out_posit
);

  localparam int BW = 2 * n;

  logic              s1_valid_q;
  enc_stage_t        s1_q;
  enc_stage_t        s1_d;
  logic              out_valid_q;
  logic [n-1:0]      out_posit_q;
  logic [n-1:0]      packed_word;
  logic              s1_load;
  logic              s2_load;

  logic signed [rs-1:0] k_s;
  int unsigned          rlen;
  logic [BW-1:0]        regime_buf;
  logic [BW-1:0]        field_buf;
  logic [BW-1:0]        build_buf;

  assign s2_load  = !out_valid_q | out_ready;
  assign s1_load  = !s1_valid_q | s2_load;
  assign in_ready = s1_load;

  always_comb begin
    k_s  = in_k;
    rlen = regime_len(k_s);
    // k>=0: k+1 leading ones (terminating zero falls out of the mask);
    // k<0: a single one after -k zeros.
    if (!k_s[rs-1]) regime_buf = ~({BW{1'b1}} >> (rlen - 1));
    else            regime_buf = {1'b1, {(BW-1){1'b0}}} >> (rlen - 1);
    field_buf = {in_e, in_frac, {(BW-es-fs){1'b0}}} >> rlen;
    build_buf = regime_buf | field_buf;

    s1_d        = '0;
    s1_d.m      = build_buf[BW-1 -: n-1];
    s1_d.g      = build_buf[BW-n];
    s1_d.s      = |build_buf[BW-n-1:0];
    s1_d.sign   = in_sign;
    s1_d.zero   = in_zero;
    s1_d.nar    = in_inf;
    s1_d.sat_hi = int'(k_s) >= (n - 2);
    s1_d.sat_lo = int'(k_s) < -(n - 2);
  end

  posit_round_pack u_round_pack (
    .st    (s1_q),
    .posit (packed_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_posit_q <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_load) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) out_posit_q <= packed_word;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_posit = out_posit_q;

endmodule

// File: tb/tb_posit_enc_8_1_pipe.sv
// Bench for the posit<8,1> encoder: directed vector table, streaming,
// back-pressure, async reset and a decoder-model round-trip sweep.
module tb_posit_enc_8_1_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_sign;
  logic [3:0] in_k;
  logic [0:0] in_e;
  logic [3:0] in_frac;
  logic       in_zero;
  logic       in_inf;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_posit;

  always #5 clk = ~clk;

  posit_enc_8_1_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_k      (in_k),
    .in_e      (in_e),
    .in_frac   (in_frac),
    .in_zero   (in_zero),
    .in_inf    (in_inf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_posit (out_posit)
  );

  typedef struct packed {
    logic       sign;
    logic [3:0] k;
    logic       e;
    logic [3:0] frac;
    logic       zero;
    logic       inf;
  } fields_t;

  typedef struct {
    fields_t    f;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] exp;
    int         cyc;
  } sb_t;

  sb_t        sbq[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         lat_chk;
  bit         accepted;
  logic [7:0] cur_exp;
  logic [7:0] held;
  vec_t       vecs[17];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent decoder model: word -> fields exactly as a decoder emits them.
  function automatic fields_t dec(logic [7:0] p);
    fields_t    f;
    logic [7:0] a;
    logic [6:0] b;
    logic       r0;
    logic [4:0] rest;
    int         run;
    int         idx;
    int         kk;
    f = '0;
    if (p == 8'h00) f.zero = 1'b1;
    else if (p == 8'h80) f.inf = 1'b1;
    else begin
      f.sign = p[7];
      a = p[7] ? -p : p;
      b = a[6:0];
      r0 = b[6];
      run = 0;
      idx = 6;
      while (idx >= 0 && b[idx] == r0) begin
        run++;
        idx--;
      end
      idx--;
      kk = r0 ? run - 1 : -run;
      for (int j = 4; j >= 0; j--) begin
        rest[j] = (idx >= 0) ? b[idx] : 1'b0;
        idx--;
      end
      f.k    = kk[3:0];
      f.e    = rest[4];
      f.frac = rest[3:0];
    end
    return f;
  endfunction

  task automatic drive(fields_t f, logic [7:0] e);
    in_valid = 1'b1;
    in_sign  = f.sign;
    in_k     = f.k;
    in_e     = f.e;
    in_frac  = f.frac;
    in_zero  = f.zero;
    in_inf   = f.inf;
    cur_exp  = e;
  endtask

  // One clock: sample handshakes mid-cycle, score output, record accept.
  task automatic cycle();
    sb_t e;
    @(negedge clk);
    accepted = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_output got %0h expected none", out_posit);
      end else begin
        e = sbq.pop_front();
        chk("out_posit", {24'b0, out_posit}, {24'b0, e.exp});
        if (lat_chk) chk("latency", cyc - e.cyc, 2);
      end
    end
    if (accepted) sbq.push_back('{cur_exp, cyc});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && sbq.size() > 0; i++) cycle();
    chk("drain_empty", sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic send_one(fields_t f, logic [7:0] e);
    int t;
    drive(f, e);
    t = 0;
    do begin
      cycle();
      t++;
    end while (!accepted && t < 5);
    chk("accept", accepted, 1);
    drain();
  endtask

  initial begin
    vecs[0]  = '{'{1'b0, 4'd0,  1'b0, 4'h0, 1'b0, 1'b0}, 8'h40};
    vecs[1]  = '{'{1'b1, 4'd0,  1'b0, 4'h0, 1'b0, 1'b0}, 8'hC0};
    vecs[2]  = '{'{1'b0, 4'hF,  1'b0, 4'h0, 1'b0, 1'b0}, 8'h20};
    vecs[3]  = '{'{1'b0, 4'd5,  1'b1, 4'h0, 1'b0, 1'b0}, 8'h7E};
    vecs[4]  = '{'{1'b0, 4'd5,  1'b1, 4'h8, 1'b0, 1'b0}, 8'h7F};
    vecs[5]  = '{'{1'b0, 4'd6,  1'b0, 4'h0, 1'b0, 1'b0}, 8'h7F};
    vecs[6]  = '{'{1'b0, 4'd7,  1'b0, 4'h0, 1'b0, 1'b0}, 8'h7F};
    vecs[7]  = '{'{1'b0, 4'hA,  1'b0, 4'h0, 1'b0, 1'b0}, 8'h01};
    vecs[8]  = '{'{1'b0, 4'h9,  1'b0, 4'h0, 1'b0, 1'b0}, 8'h01};
    vecs[9]  = '{'{1'b0, 4'h8,  1'b0, 4'h0, 1'b0, 1'b0}, 8'h01};
    vecs[10] = '{'{1'b0, 4'd0,  1'b0, 4'h0, 1'b1, 1'b1}, 8'h80};
    vecs[11] = '{'{1'b1, 4'd3,  1'b1, 4'h5, 1'b1, 1'b0}, 8'h00};
    vecs[12] = '{'{1'b1, 4'd7,  1'b0, 4'h0, 1'b0, 1'b0}, 8'h81};
    vecs[13] = '{'{1'b1, 4'h8,  1'b0, 4'h0, 1'b0, 1'b0}, 8'hFF};
    vecs[14] = '{'{1'b0, 4'd1,  1'b1, 4'hA, 1'b0, 1'b0}, 8'h6D};
    vecs[15] = '{'{1'b1, 4'd2,  1'b0, 4'hB, 1'b0, 1'b0}, 8'h8D};
    vecs[16] = '{'{1'b0, 4'd2,  1'b1, 4'h6, 1'b0, 1'b0}, 8'h76};

    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_k = '0; in_e = '0;
    in_frac = '0; in_zero = 1'b0; in_inf = 1'b0; out_ready = 1'b1;
    cur_exp = '0; lat_chk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_posit", out_posit, 0);
    chk("reset_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) send_one(vecs[i].f, vecs[i].exp);

    // Streaming: random nonzero, non-NaR words round-trip back-to-back.
    for (int i = 0; i < 16; i++) begin
      logic [7:0] p;
      p = 8'($urandom_range(1, 255));
      if (p == 8'h80) p = 8'h40;
      drive(dec(p), p);
      cycle();
      chk("in_ready_stream", accepted, 1);
    end
    drain();

    // Full round-trip sweep; 0x00/0x80 come back via the flag paths.
    for (int w = 0; w < 256; w++) begin
      drive(dec(8'(w)), 8'(w));
      cycle();
      chk("in_ready_sweep", accepted, 1);
    end
    drain();

    // Back-pressure: two items fill the pipe, a third is refused.
    lat_chk = 1'b0;
    out_ready = 1'b0;
    drive(dec(8'h35), 8'h35);
    cycle();
    chk("bp_accept_a", accepted, 1);
    drive(dec(8'hB2), 8'hB2);
    cycle();
    chk("bp_accept_b", accepted, 1);
    drive(dec(8'h5A), 8'h5A);
    held = out_posit;
    chk("bp_head", {24'b0, held}, 32'h35);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_refused", accepted, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_stable", {24'b0, out_posit}, {24'b0, held});
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10 && (in_valid || sbq.size() > 0); i++) begin
      cycle();
      if (accepted) in_valid = 1'b0;
    end
    chk("bp_c_taken", in_valid, 0);
    chk("bp_drained", sbq.size(), 0);
    sbq.delete();
    lat_chk = 1'b1;

    // Asynchronous reset with two items in flight.
    out_ready = 1'b0;
    drive(dec(8'h44), 8'h44);
    cycle();
    drive(dec(8'h23), 8'h23);
    cycle();
    in_valid = 1'b0;
    chk("rst_pre_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_posit", out_posit, 0);
    sbq.delete();
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("rst_no_stale", out_valid, 0);
    end
    send_one(vecs[14].f, vecs[14].exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
